// File: rtl/tnoc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tnoc_pkg
//  Brief    : Shared NoC types: configuration, port kind, flit and decode helpers.
//  Revision : 1.0
// ============================================================================
package tnoc_pkg;

    typedef struct packed {
        int virtual_channels;
    } tnoc_config;

    localparam tnoc_config TNOC_DEFAULT_CONFIG = '{virtual_channels: 4};

    typedef enum logic [0:0] {
        TNOC_LOCAL_PORT    = 1'b0,
        TNOC_INTERNAL_PORT = 1'b1
    } tnoc_port_type;

    localparam int TNOC_DATA_WIDTH = 32;

    typedef enum logic [0:0] {
        TNOC_PAYLOAD_FLIT = 1'b0,
        TNOC_HEADER_FLIT  = 1'b1
    } tnoc_flit_type;

    typedef struct packed {
        tnoc_flit_type              flit_type;
        logic                       tail;
        logic [TNOC_DATA_WIDTH-1:0] data;
    } tnoc_flit;

    function automatic logic is_header_flit(tnoc_flit flit);
        return flit.flit_type == TNOC_HEADER_FLIT;
    endfunction

    function automatic logic is_tail_flit(tnoc_flit flit);
        return flit.tail;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tnoc_flit_if.sv
`default_nettype none
// ============================================================================
//  Module   : tnoc_flit_if
//  Brief    : Valid/ready flit stream with one valid/ready pair per channel.
//  Revision : 1.0
// ============================================================================
interface tnoc_flit_if
    import tnoc_pkg::*;
#(
    parameter tnoc_config    CONFIG    = TNOC_DEFAULT_CONFIG,
    parameter tnoc_port_type PORT_TYPE = TNOC_LOCAL_PORT,
    parameter int            CHANNELS  = CONFIG.virtual_channels
);
    logic [CHANNELS-1:0] valid;
    logic [CHANNELS-1:0] ready;
    tnoc_flit            flit;

    modport initiator (
        output valid,
        input  ready,
        output flit
    );

    modport target (
        input  valid,
        output ready,
        input  flit
    );
endinterface
`default_nettype wire

// File: rtl/tnoc_round_robin_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tnoc_round_robin_arbiter
//  Brief    : Combinational one-hot grant to the first requester at or after
//             the one-hot priority position, searching circularly.
//  Revision : 1.0
// ============================================================================
module tnoc_round_robin_arbiter #(
    parameter int CHANNELS = 2
)(
    input  logic [CHANNELS-1:0] i_request,
    input  logic [CHANNELS-1:0] i_priority,
    output logic [CHANNELS-1:0] o_grant
);
    logic [2*CHANNELS-1:0] w_double_request;
    logic [2*CHANNELS-1:0] w_double_grant;

    // Subtracting the priority from the doubled request isolates the lowest
    // request bit at or above the priority position, wrapping via the copy.
    assign w_double_request = {i_request, i_request};
    assign w_double_grant   = w_double_request
                            & ~(w_double_request - {{CHANNELS{1'b0}}, i_priority});
    assign o_grant          = w_double_grant[CHANNELS-1:0]
                            | w_double_grant[2*CHANNELS-1:CHANNELS];
endmodule
`default_nettype wire

// File: rtl/tnoc_input_vc_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tnoc_input_vc_arbiter
//  Brief    : Packet-granular round-robin selection of one VC flit stream onto
//             a single output stream, zero-latency mux, registered grant.
//  Revision : 1.0
// ============================================================================
module tnoc_input_vc_arbiter
    import tnoc_pkg::*;
#(
    parameter tnoc_config    CONFIG    = TNOC_DEFAULT_CONFIG,
    parameter tnoc_port_type PORT_TYPE = TNOC_LOCAL_PORT,
    localparam int           CHANNELS  = CONFIG.virtual_channels
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_clear,
    output logic [CHANNELS-1:0] o_vc_grant,
    output logic                o_vc_busy,
    tnoc_flit_if.target         flit_in_if [CHANNELS],
    tnoc_flit_if.initiator      flit_out_if
);
    localparam logic [CHANNELS-1:0] c_priority_init = CHANNELS'(1);

    logic                r_lock;
    logic [CHANNELS-1:0] r_grant;
    logic [CHANNELS-1:0] r_priority;

    logic [CHANNELS-1:0] w_valid;
    logic [CHANNELS-1:0] w_request;
    logic [CHANNELS-1:0] w_route;
    logic [CHANNELS-1:0] w_select;
    logic [CHANNELS-1:0] w_priority_next;
    tnoc_flit            w_flit [CHANNELS];
    tnoc_flit            w_out_flit;
    logic                w_out_valid;
    logic                w_handshake;

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_vc
            assign w_valid[i]            = flit_in_if[i].valid[0];
            assign w_flit[i]             = flit_in_if[i].flit;
            assign w_request[i]          = w_valid[i] && is_header_flit(w_flit[i]);
            assign flit_in_if[i].ready[0] = w_select[i] && flit_out_if.ready[0];

            a_no_orphan_payload: assert property (
                @(posedge clk) disable iff (!rst_n)
                !(!r_lock && w_valid[i] && !is_header_flit(w_flit[i]))
            ) else $error("non-header flit on VC %0d while idle (port type %0d)", i, PORT_TYPE);
        end

        if (CHANNELS == 1) begin : g_passthrough
            assign w_route         = 1'b1;
            assign w_priority_next = w_select;
        end else begin : g_arbitrated
            logic [CHANNELS-1:0] w_arb_grant;

            tnoc_round_robin_arbiter #(
                .CHANNELS (CHANNELS)
            ) u_arbiter (
                .i_request  (w_request),
                .i_priority (r_priority),
                .o_grant    (w_arb_grant)
            );

            assign w_route         = r_lock ? r_grant : w_arb_grant;
            assign w_priority_next = {w_select[CHANNELS-2:0], w_select[CHANNELS-1]};
        end
    endgenerate

    // Nothing is connected while reset is held, regardless of upstream valids.
    assign w_select = rst_n ? w_route : '0;

    always_comb begin
        w_out_flit = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_select[k]) w_out_flit = w_flit[k];
        end
    end

    assign w_out_valid          = |(w_select & w_valid);
    assign w_handshake          = w_out_valid && flit_out_if.ready[0];
    assign flit_out_if.valid[0] = w_out_valid;
    assign flit_out_if.flit     = w_out_flit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock     <= 1'b0;
            r_grant    <= '0;
            r_priority <= c_priority_init;
        end else if (i_clear) begin
            r_lock     <= 1'b0;
            r_grant    <= '0;
            r_priority <= c_priority_init;
        end else if (w_handshake) begin
            if (is_tail_flit(w_out_flit)) begin
                r_lock     <= 1'b0;
                r_grant    <= '0;
                r_priority <= w_priority_next;
            end else if (!r_lock) begin
                r_lock  <= 1'b1;
                r_grant <= w_select;
            end
        end
    end

    assign o_vc_grant = r_grant;
    assign o_vc_busy  = r_lock;
endmodule
`default_nettype wire

// File: tb/tb_tnoc_input_vc_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tnoc_input_vc_arbiter
//  Brief    : Randomized and directed bench for the input VC arbiter, checked
//             every cycle against a packet-level model of the arbitration rules.
//  Revision : 1.0
// ============================================================================
module tb_tnoc_input_vc_arbiter;
    import tnoc_pkg::*;

    localparam int         CH  = 4;
    localparam tnoc_config CFG = '{virtual_channels: CH};

    logic          clk;
    logic          rst_n;
    logic          i_clear;
    logic [CH-1:0] vc_grant;
    logic          vc_busy;
    logic [CH-1:0] src_valid;
    tnoc_flit      src_flit [CH];
    logic [CH-1:0] src_ready;
    logic          out_ready;
    logic          out_valid;
    tnoc_flit      out_flit;

    tnoc_flit_if #(.CONFIG(CFG), .CHANNELS(1)) in_if [CH] ();
    tnoc_flit_if #(.CONFIG(CFG), .CHANNELS(1)) out_if ();

    genvar g;
    generate
        for (g = 0; g < CH; g++) begin : g_src
            assign in_if[g].valid[0] = src_valid[g];
            assign in_if[g].flit     = src_flit[g];
            assign src_ready[g]      = in_if[g].ready[0];
        end
    endgenerate
    assign out_if.ready[0] = out_ready;
    assign out_valid       = out_if.valid[0];
    assign out_flit        = out_if.flit;

    tnoc_input_vc_arbiter #(.CONFIG(CFG), .PORT_TYPE(TNOC_LOCAL_PORT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (i_clear),
        .o_vc_grant  (vc_grant),
        .o_vc_busy   (vc_busy),
        .flit_in_if  (in_if),
        .flit_out_if (out_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Source state: each VC works through one packet of len flits at a time.
    bit active [CH];
    int len    [CH];
    int pos    [CH];
    int pid    [CH];
    int mode;
    // Model state: lock flag, locked VC index, priority VC index.
    bit m_lock;
    int m_vc;
    int m_prio;
    // Last observed DUT values, for literal checks.
    logic          obs_valid;
    logic [CH-1:0] obs_ready;
    int            obs_vc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic tnoc_flit mk_flit(input int v);
        tnoc_flit f;
        f.flit_type = (pos[v] == 0) ? TNOC_HEADER_FLIT : TNOC_PAYLOAD_FLIT;
        f.tail      = (pos[v] == len[v] - 1);
        f.data      = {8'(v), 16'(pid[v]), 8'(pos[v])};
        return f;
    endfunction

    task automatic start_pkt(input int v, input int l);
        active[v] = 1'b1;
        len[v]    = l;
        pos[v]    = 0;
        pid[v]    = pid[v] + 1;
    endtask

    task automatic model_reset();
        m_lock = 1'b0;
        m_vc   = 0;
        m_prio = 0;
        for (int i = 0; i < CH; i++) begin
            active[i] = 1'b0;
            pos[i]    = 0;
        end
    endtask

    task automatic step();
        int            sel;
        bit            exp_valid;
        logic [CH-1:0] exp_ready;
        bit            hs;
        for (int i = 0; i < CH; i++) begin
            if (!active[i] && (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)))
                start_pkt(i, (mode == 1) ? 1 : int'($urandom_range(1, 5)));
            src_valid[i] = active[i] && !(mode == 2 && pos[i] > 0 && $urandom_range(0, 4) == 0);
            src_flit[i]  = mk_flit(i);
        end
        out_ready = (mode == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (mode == 2) i_clear = ($urandom_range(0, 199) == 0);

        sel = -1;
        if (m_lock) sel = m_vc;
        else begin
            for (int k = 0; k < CH; k++) begin
                int j;
                j = (m_prio + k) % CH;
                if (sel < 0 && src_valid[j] && pos[j] == 0) sel = j;
            end
        end
        exp_valid = (sel >= 0) && src_valid[sel];
        exp_ready = '0;
        if (sel >= 0) exp_ready[sel] = out_ready;

        @(negedge clk);
        check("grant", 64'(vc_grant), m_lock ? (64'd1 << m_vc) : 64'd0);
        check("busy", 64'(vc_busy), 64'(m_lock));
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        check("in_ready", 64'(src_ready), 64'(exp_ready));
        if (exp_valid) check("out_flit", 64'(out_flit), 64'(src_flit[sel]));
        obs_valid = out_valid;
        obs_ready = src_ready;
        if (out_valid && out_ready) obs_vc = int'(out_flit.data[31:24]);
        hs = exp_valid && out_ready;

        @(posedge clk);
        if (i_clear) model_reset();
        else if (hs) begin
            if (pos[sel] == len[sel] - 1) begin
                m_lock      = 1'b0;
                m_prio      = (sel + 1) % CH;
                active[sel] = 1'b0;
                pos[sel]    = 0;
            end else begin
                if (!m_lock) begin
                    m_lock = 1'b1;
                    m_vc   = sel;
                end
                pos[sel]++;
            end
        end
        #1;
    endtask

    // Called at posedge+1: reset lands mid-cycle and is checked before any edge.
    task automatic async_reset_check();
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_grant", 64'(vc_grant), 64'd0);
        check("rst_busy", 64'(vc_busy), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(src_ready), 64'd0);
        model_reset();
        src_valid = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        i_clear   = 1'b0;
        out_ready = 1'b0;
        src_valid = '0;
        mode      = 0;
        obs_vc    = -1;
        for (int i = 0; i < CH; i++) begin
            src_flit[i] = '0;
            pid[i]      = 0;
            len[i]      = 1;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset.
        check("reset_grant", 64'(vc_grant), 64'd0);
        check("reset_busy", 64'(vc_busy), 64'd0);
        step();
        check("idle_out_valid", 64'(obs_valid), 64'd0);
        check("idle_in_ready", 64'(obs_ready), 64'd0);

        // Four-flit packet on VC0.
        start_pkt(0, 4);
        step();
        check("pkt0_busy_after_hdr", 64'(vc_busy), 64'd1);
        check("pkt0_grant", 64'(vc_grant), 64'h1);
        step();
        step();
        check("pkt0_busy_mid", 64'(vc_busy), 64'd1);
        step();
        check("pkt0_busy_after_tail", 64'(vc_busy), 64'd0);
        check("pkt0_grant_after_tail", 64'(vc_grant), 64'd0);

        // Clear after two of four flits on VC2 (priority at VC1 beforehand).
        start_pkt(2, 4);
        step();
        step();
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        check("clear_busy", 64'(vc_busy), 64'd0);
        check("clear_grant", 64'(vc_grant), 64'd0);
        start_pkt(0, 1);
        start_pkt(3, 1);
        step();
        check("clear_prio_vc0_first", 64'(obs_vc), 64'd0);
        step();
        check("then_vc3", 64'(obs_vc), 64'd3);

        // Back-to-back single-flit packets on all VCs rotate strictly.
        mode = 1;
        for (int k = 0; k < 8; k++) begin
            step();
            check("rotation_vc", 64'(obs_vc), 64'(k % CH));
            check("rotation_no_busy", 64'(vc_busy), 64'd0);
        end
        mode = 0;
        repeat (5) step();

        // Async reset in the middle of a packet.
        start_pkt(1, 4);
        step();
        step();
        check("pre_reset_busy", 64'(vc_busy), 64'd1);
        async_reset_check();

        // Random traffic, backpressure, bubbles and occasional clears.
        mode = 2;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (c == 1500) async_reset_check();
        end
        mode    = 0;
        i_clear = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
